// File: rtl/ntt_loop_scheduler_pkg.sv
// Shared types, sizing constants and stage-limit helper for the radix-4
// NTT loop scheduler. Optional build macro used by this slice: NTT_INV_EN.
package ntt_sched_pkg;

    localparam int NTT_STAGES = 5;
    localparam int NTT_IDX_W  = 8;
    localparam int NTT_P_W    = 3;
    localparam int NTT_GAP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } sched_state_t;

    typedef struct packed {
        logic [NTT_IDX_W-1:0] j_max;
        logic [NTT_IDX_W-1:0] k_max;
    } stage_lim_t;

    // j_max = 4^p - 1 and k_max = 4^(4-p) - 1; stages above 4 are clamped
    // so a corrupted stage value can never produce a zero-width loop.
    function automatic stage_lim_t stage_limits(input logic [NTT_P_W-1:0] p);
        stage_lim_t  lim;
        int unsigned jp;
        int unsigned kp;
        jp = (p > NTT_P_W'(4)) ? 32'd4 : 32'(p);
        kp = 32'd4 - jp;
        lim.j_max = NTT_IDX_W'((32'd1 << (2 * jp)) - 32'd1);
        lim.k_max = NTT_IDX_W'((32'd1 << (2 * kp)) - 32'd1);
        return lim;
    endfunction

endpackage

// File: rtl/ntt_loop_scheduler_if.sv
// Control and tuple bus between the NTT loop scheduler and its consumer
// (address generator / memory-read pipeline). The inv select only exists
// when NTT_INV_EN is defined.
interface ntt_loop_scheduler_if;
    import ntt_sched_pkg::*;

    logic                 start;
    logic                 abort;
    logic                 ready;
    logic                 valid;
    logic [NTT_IDX_W-1:0] k;
    logic [NTT_IDX_W-1:0] j;
    logic [NTT_P_W-1:0]   p;
    logic                 stage_last;
    logic                 last;
    logic                 busy;
    logic                 done;
`ifdef NTT_INV_EN
    logic                 inv;

    modport master (
        input  start, abort, ready, inv,
        output valid, k, j, p, stage_last, last, busy, done
    );

    modport slave (
        output start, abort, ready, inv,
        input  valid, k, j, p, stage_last, last, busy, done
    );
`else
    modport master (
        input  start, abort, ready,
        output valid, k, j, p, stage_last, last, busy, done
    );

    modport slave (
        output start, abort, ready,
        input  valid, k, j, p, stage_last, last, busy, done
    );
`endif

endinterface

// File: rtl/ntt_loop_scheduler_counter.sv
// Nested j (inner) / k (outer) butterfly-group counters for one NTT stage.
// wrap flags the terminal position of the stage (j == j_max and k == k_max).
module ntt_loop_counter
    import ntt_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [NTT_IDX_W-1:0] j_max,
    input  logic [NTT_IDX_W-1:0] k_max,
    output logic [NTT_IDX_W-1:0] k,
    output logic [NTT_IDX_W-1:0] j,
    output logic                 wrap
);

    logic j_end;
    logic k_end;

    assign j_end = (j == j_max);
    assign k_end = (k == k_max);
    assign wrap  = j_end && k_end;

    // Step j each advance; on j wrap step k, and on k wrap return both to 0.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            k <= '0;
            j <= '0;
        end else if (advance) begin
            if (j_end) begin
                j <= '0;
                k <= k_end ? '0 : k + NTT_IDX_W'(1);
            end else begin
                j <= j + NTT_IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/ntt_loop_scheduler.sv
// Radix-4 NTT loop scheduler: walks stages p and groups (k, j) of a
// 1024-point transform, one tuple per handshake, with STAGE_GAP bubble
// cycles between stages. Define NTT_INV_EN to add the inv port, which
// reverses the stage order (0 -> 4) for the inverse transform.
module ntt_loop_scheduler
    import ntt_sched_pkg::*;
#(
    parameter int unsigned STAGE_GAP = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ntt_loop_scheduler_if.master  bus
);

    localparam logic [NTT_P_W-1:0]   P_TOP    = NTT_P_W'(NTT_STAGES - 1);
    localparam logic [NTT_GAP_W-1:0] GAP_LOAD = NTT_GAP_W'(STAGE_GAP);

    sched_state_t          state;
    sched_state_t          state_n;
    logic [NTT_P_W-1:0]    p_q;
    logic [NTT_P_W-1:0]    p_n;
    logic [NTT_GAP_W-1:0]  gap_q;
    logic [NTT_GAP_W-1:0]  gap_n;
    logic                  inv_q;
    logic                  inv_start;
    logic                  cnt_clear;
    logic                  cnt_adv;
    logic                  wrap;
    logic [NTT_IDX_W-1:0]  k_cnt;
    logic [NTT_IDX_W-1:0]  j_cnt;
    logic [NTT_P_W-1:0]    final_p;
    logic [NTT_P_W-1:0]    next_p;
    stage_lim_t            lim;

`ifdef NTT_INV_EN
    logic inv_n;

    assign inv_start = bus.inv;

    // The stage direction is captured once, when start is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_n;
        end
    end
`else
    assign inv_start = 1'b0;
    assign inv_q     = 1'b0;
`endif

    assign lim     = stage_limits(p_q);
    assign final_p = inv_q ? P_TOP : '0;
    assign next_p  = inv_q ? p_q + NTT_P_W'(1) : p_q - NTT_P_W'(1);

    ntt_loop_counter u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .j_max   (lim.j_max),
        .k_max   (lim.k_max),
        .k       (k_cnt),
        .j       (j_cnt),
        .wrap    (wrap)
    );

    // State, stage and bubble-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            p_q   <= '0;
            gap_q <= '0;
        end else begin
            state <= state_n;
            p_q   <= p_n;
            gap_q <= gap_n;
        end
    end

    // Next-state logic: abort flushes everything back to the reset picture;
    // otherwise step tuples in RUN, count down bubbles in GAP, pulse DONE.
    always_comb begin
        state_n   = state;
        p_n       = p_q;
        gap_n     = gap_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
`ifdef NTT_INV_EN
        inv_n     = inv_q;
`endif
        if (bus.abort) begin
            state_n   = ST_IDLE;
            p_n       = '0;
            gap_n     = '0;
            cnt_clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_n   = ST_RUN;
                        cnt_clear = 1'b1;
                        p_n       = inv_start ? '0 : P_TOP;
`ifdef NTT_INV_EN
                        inv_n     = bus.inv;
`endif
                    end
                end
                ST_RUN: begin
                    if (bus.ready) begin
                        cnt_adv = 1'b1;
                        if (wrap) begin
                            if (p_q == final_p) begin
                                state_n = ST_DONE;
                                p_n     = '0;
                            end else begin
                                p_n = next_p;
                                if (STAGE_GAP != 0) begin
                                    state_n = ST_GAP;
                                    gap_n   = GAP_LOAD;
                                end
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q <= NTT_GAP_W'(1)) begin
                        state_n = ST_RUN;
                        gap_n   = '0;
                    end else begin
                        gap_n = gap_q - NTT_GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.valid      = (state == ST_RUN);
    assign bus.k          = k_cnt;
    assign bus.j          = j_cnt;
    assign bus.p          = p_q;
    assign bus.stage_last = bus.valid && wrap;
    assign bus.last       = bus.stage_last && (p_q == final_p);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);

endmodule

// File: tb/tb_ntt_loop_scheduler.sv
// Scoreboard bench for ntt_loop_scheduler: a reference model expands the
// full tuple sequence into a queue on each start, and a monitor pops and
// compares on every handshake. A second instance covers STAGE_GAP = 0.
// Define NTT_INV_EN to add the inverse-order run.
module tb_ntt_loop_scheduler;
    import ntt_sched_pkg::*;

    localparam int GAP_MAIN = 2;

    typedef struct packed {
        logic [7:0] k;
        logic [7:0] j;
        logic [2:0] p;
        logic       sl;
        logic       last;
    } tuple_t;

    logic clk;
    logic rst_n;

    ntt_loop_scheduler_if bus ();
    ntt_loop_scheduler_if bus0 ();

    ntt_loop_scheduler #(.STAGE_GAP(GAP_MAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ntt_loop_scheduler #(.STAGE_GAP(0)) dut_g0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    tuple_t exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     hs_count = 0;
    int     done_count = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: every stage in order, k outer, j inner, 256 tuples each.
    task automatic pushTransform(input bit inv_mode);
        for (int s = 0; s < 5; s++) begin
            int pp;
            int jm;
            int km;
            pp = inv_mode ? s : 4 - s;
            jm = (1 << (2 * pp)) - 1;
            km = (1 << (8 - 2 * pp)) - 1;
            for (int kk = 0; kk <= km; kk++) begin
                for (int jj = 0; jj <= jm; jj++) begin
                    tuple_t t;
                    t.k    = 8'(kk);
                    t.j    = 8'(jj);
                    t.p    = 3'(pp);
                    t.sl   = (kk == km) && (jj == jm);
                    t.last = t.sl && (s == 4);
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    function automatic tuple_t sampleMain();
        tuple_t t;
        t.k    = bus.k;
        t.j    = bus.j;
        t.p    = bus.p;
        t.sl   = bus.stage_last;
        t.last = bus.last;
        return t;
    endfunction

    task automatic applyStimulus(input bit do_start, input bit do_abort);
        @(posedge clk);
        #1;
        bus.start = do_start;
        bus.abort = do_abort;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic waitDone(input int budget, input bit random_ready,
                            input int busy_start_at, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (random_ready) bus.ready = 1'($urandom_range(0, 1));
            bus.start = (i == busy_start_at);
            @(negedge clk);
            if (bus.done) begin
                cycles = i;
                break;
            end
        end
        bus.start = 1'b0;
        bus.ready = 1'b1;
        if (cycles < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks bubbles,
    // done pulse and stall stability of the main instance.
    initial begin
        tuple_t e;
        tuple_t cur;
        tuple_t prev;
        bit     expect_done;
        bit     stall_prev;
        bit     resume_check;
        int     gap_left;
        expect_done  = 0;
        stall_prev   = 0;
        resume_check = 0;
        gap_left     = 0;
        prev         = '0;
        forever begin
            @(negedge clk);
            cur = sampleMain();
            if (!rst_n || bus.abort) begin
                expect_done  = 0;
                stall_prev   = 0;
                resume_check = 0;
                gap_left     = 0;
            end else begin
                if (expect_done || bus.done) begin
                    checkOutput("done_pulse", 32'(bus.done), 32'(expect_done));
                    if (bus.done) done_count++;
                end
                expect_done = 0;
                if (gap_left > 0) begin
                    checkOutput("gap_valid_low", 32'(bus.valid), 32'd0);
                    gap_left--;
                    if (gap_left == 0) resume_check = 1;
                end else if (resume_check) begin
                    checkOutput("gap_resume", 32'(bus.valid), 32'd1);
                    resume_check = 0;
                end
                if (stall_prev) begin
                    checkOutput("stall_valid", 32'(bus.valid), 32'd1);
                    checkOutput("stall_hold", 32'(cur), 32'(prev));
                end
                if (bus.valid && bus.ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_tuple", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("tuple", 32'(cur), 32'(e));
                        checkOutput("busy_while_valid", 32'(bus.busy), 32'd1);
                        if (e.last) expect_done = 1;
                        else if (e.sl && GAP_MAIN > 0) gap_left = GAP_MAIN;
                    end
                    hs_count++;
                end
                stall_prev = bus.valid && !bus.ready;
                prev       = cur;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cyc;
        bit  found;
        bit  at_end;
        bit  boundary_seen;
        int  g0_done;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.ready  = 1'b0;
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        bus0.ready = 1'b0;
`ifdef NTT_INV_EN
        bus.inv    = 1'b0;
        bus0.inv   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(bus.valid), 32'd0);
        checkOutput("rst_k", 32'(bus.k), 32'd0);
        checkOutput("rst_j", 32'(bus.j), 32'd0);
        checkOutput("rst_p", 32'(bus.p), 32'd0);
        checkOutput("rst_stage_last", 32'(bus.stage_last), 32'd0);
        checkOutput("rst_last", 32'(bus.last), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] forward run, ready held high");
        bus.ready = 1'b1;
        hs_count  = 0;
        pushTransform(1'b0);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("start_valid", 32'(bus.valid), 32'd1);
        checkOutput("start_busy", 32'(bus.busy), 32'd1);
        waitDone(3000, 1'b0, -1, cyc);
        checkOutput("done_latency", 32'(cyc), 32'd1288);
        @(negedge clk);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("fwd_hs_count", 32'(hs_count), 32'd1280);
        checkOutput("fwd_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] random backpressure with start while busy");
        hs_count = 0;
        pushTransform(1'b0);
        applyStimulus(1'b1, 1'b0);
        waitDone(8000, 1'b1, 500, cyc);
        @(negedge clk);
        checkOutput("bp_hs_count", 32'(hs_count), 32'd1280);
        checkOutput("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("bp_idle_busy", 32'(bus.busy), 32'd0);

        $display("[TB] abort mid-stage then restart");
        pushTransform(1'b0);
        applyStimulus(1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.valid && bus.p == 3'd2 && bus.k == 8'd5) begin
                found = 1;
                break;
            end
        end
        checkOutput("abort_reach_p2", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_valid", 32'(bus.valid), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_kjp", {13'd0, bus.k, bus.j, bus.p}, 32'd0);
        hs_count = 0;
        pushTransform(1'b0);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("restart_first", {13'd0, bus.k, bus.j, bus.p}, {13'd0, 8'd0, 8'd0, 3'd4});
        waitDone(3000, 1'b0, 200, cyc);
        @(negedge clk);
        checkOutput("restart_hs_count", 32'(hs_count), 32'd1280);

        $display("[TB] start and abort together in idle");
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("start_abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("start_abort_valid", 32'(bus.valid), 32'd0);

        $display("[TB] zero stage gap instance");
        bus0.ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        at_end        = 0;
        boundary_seen = 0;
        g0_done       = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (at_end) begin
                checkOutput("g0_next_stage", {12'd0, bus0.valid, bus0.k, bus0.j, bus0.p},
                            {12'd0, 1'b1, 8'd0, 8'd0, 3'd3});
                at_end        = 0;
                boundary_seen = 1;
            end
            if (bus0.valid && bus0.stage_last && bus0.p == 3'd4) begin
                checkOutput("g0_stage_end", {16'd0, bus0.k, bus0.j}, {16'd0, 8'd0, 8'd255});
                at_end = 1;
            end
            if (bus0.done) begin
                g0_done = i;
                break;
            end
        end
        checkOutput("g0_boundary_seen", 32'(boundary_seen), 32'd1);
        checkOutput("g0_done_latency", 32'(g0_done), 32'd1280);

`ifdef NTT_INV_EN
        $display("[TB] inverse stage order");
        bus.inv  = 1'b1;
        hs_count = 0;
        pushTransform(1'b1);
        applyStimulus(1'b1, 1'b0);
        bus.inv = 1'b0;
        @(negedge clk);
        checkOutput("inv_first", {13'd0, bus.k, bus.j, bus.p}, 32'd0);
        waitDone(3000, 1'b0, -1, cyc);
        checkOutput("inv_done_latency", 32'(cyc), 32'd1288);
        @(negedge clk);
        checkOutput("inv_hs_count", 32'(hs_count), 32'd1280);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
